hsmooth_filter: RTL and testbench
=================================

Name: hsmooth_filter

Overview:
- Horizontal 3-tap smoothing stage placed between image_read and image_write.
- Consumes the two-pixels-per-clock RGB stream qualified by HSYNC.
- Emits the filtered stream with the identical port shape (HSYNC plus R0/G0/B0/R1/G1/B1), so it drops in without changes to either neighbour.
- Filter: out[i] = (p[i-1] + 2*p[i] + p[i+1] + 2) >> 2 per channel, with edge replication at line ends.

Parameters:
- WIDTH, 768, pixels per line; must be even and >= 4.
- HEIGHT, 512, lines per frame.

Ports:
- HCLK  in  1  clock; all logic rising-edge.
- HRESET  in  1  reset; synchronous, active-low.
- ENABLE  in  1  1 = filter, 0 = bypass with identical latency; sampled per accepted pair.
- HSYNC  in  1  input pair valid.
- DATA_R0/G0/B0  in  8 each  even (left) pixel of pair.
- DATA_R1/G1/B1  in  8 each  odd (right) pixel of pair.
- HSYNC_O  out  1  output pair valid.
- DATA_R0_O/G0_O/B0_O  out  8 each  filtered even pixel.
- DATA_R1_O/G1_O/B1_O  out  8 each  filtered odd pixel.
- frame_done  out  1  one-cycle pulse with the last output pair of a frame.

Behaviour:
- Reset (HRESET=0 at a clock edge): all outputs 0; pair counter, line counter, flush flag and pipeline registers cleared.
- Reset applied mid-line discards all partial state. The next accepted pair is pair 0 of line 0.
- Line structure:
  - Input pair counter k runs 0..WIDTH/2-1 and increments only on HSYNC=1.
  - It wraps to 0 after the last pair.
  - HSYNC may drop for any number of cycles anywhere, including inside a line. State holds during the gap.
- Pipeline:
  - Registers hold the previous pair P (index k-1) and the last pixel L of pair k-2.
  - When pair k (k>=1) is accepted, output pair k-1 is computed from L, P and the even pixel of pair k.
  - That output is registered and presented the next cycle with HSYNC_O=1.
- Line flush:
  - Accepting pair WIDTH/2-1 sets a flush flag.
  - On the next cycle, output pair WIDTH/2-1 is emitted regardless of HSYNC, using replicated right edge p[WIDTH] = p[WIDTH-1].
  - So the last pair emits two cycles after acceptance; all other pairs emit one cycle after their successor is accepted.
- Left edge: pair 0 uses p[-1] = p[0].
- Pair 0 emits nothing on acceptance. HSYNC_O stays 0 in that cycle unless a flush occurs.
- Flush and the next line's pair 0 in the same cycle:
  - Both proceed.
  - The flush uses a dedicated snapshot of the last pair, not P.
  - No pixel of either line is mixed into the other's computation.
- Output count is exactly WIDTH/2 HSYNC_O pulses per line. Output order equals input order.
- Arithmetic:
  - 10-bit unsigned intermediate; add 2 for rounding, then shift right 2.
  - The result fits in 8 bits without saturation (maximum 1022>>2 = 255).
- Bypass: ENABLE=0 at pair acceptance forwards that pair unchanged, on the same emit cycle it would have had filtered.
- Line counter increments on each flush. frame_done=1 in the cycle the flush of line HEIGHT-1 is emitted, then the counter wraps to 0.
- HSYNC_O is 0 and data outputs hold their last values whenever no pair is emitted.

Decomposition:
- Shared package/header (alongside existing parameter defines):
  - default WIDTH and HEIGHT;
  - pixel width 8;
  - pairs-per-line derived constant.
- One sub-module: hsmooth_tap3, a purely combinational per-channel (a, b, c) -> (a + 2b + c + 2) >> 2.
  - Instantiated six times: 3 channels x 2 pixels.
  - Edge muxing stays in hsmooth_filter.

Test Plan:
- WIDTH=8, HEIGHT=2, constant 100 on all channels with HSYNC continuous -> every output 100; exactly 4 HSYNC_O pulses per line; frame_done once, on the 8th output pair.
- R ramp p[i]=10*i (0..70) on one line -> R out = 3,10,20,30,40,50,60,68. G/B untouched.
- Impulse p[3]=255, others 0 -> outputs 0,0,64,128,64,0,0,0.
- HSYNC pattern 1,0,0,1,1,0,1 within a line -> same data values as the continuous case; each output one cycle after the next pair is accepted.
- Back-to-back lines: line A all 200, line B all 0, no gap -> A's last output pair is 200,200 (no B leakage); B's first output pair is 0,0.
- HRESET=0 for one cycle after pair 2 of a line -> outputs 0 that cycle; the following 4 pairs are treated as pair 0..3 of line 0. With ENABLE=0, ramp data passes unchanged at identical timing.

Source files
------------

// File: rtl/hsmooth_filter_pkg.sv
// hsmooth_filter_pkg: shared geometry defaults, pixel width and RGB pair types
package hsmooth_filter_pkg;
  localparam int DEF_WIDTH = 768;
  localparam int DEF_HEIGHT = 512;
  localparam int PIX_W = 8;
  localparam int DEF_PAIRS = DEF_WIDTH / 2;
  typedef logic [2:0][PIX_W-1:0] rgb_t;
  typedef logic [1:0][2:0][PIX_W-1:0] pair_t;
endpackage

// File: rtl/hsmooth_tap3.sv
// hsmooth_tap3: combinational rounded 1-2-1 tap y = (a + 2b + c + 2) >> 2 on one channel
module hsmooth_tap3
  import hsmooth_filter_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  output logic [PIX_W-1:0] y
);
  logic [PIX_W+1:0] s;
  assign s = (PIX_W+2)'(a) + {1'b0, b, 1'b0} + (PIX_W+2)'(c) + (PIX_W+2)'(2);
  assign y = s[PIX_W+1:2];
endmodule

// File: rtl/hsmooth_filter.sv
// hsmooth_filter: 3-tap horizontal smoother on a 2-pixel/clk RGB stream (HCLK, active-low sync HRESET, ENABLE bypass, HSYNC/DATA_* in, HSYNC_O/DATA_*_O/frame_done out)
module hsmooth_filter
  import hsmooth_filter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             ENABLE,
  input  logic             HSYNC,
  input  logic [PIX_W-1:0] DATA_R0,
  input  logic [PIX_W-1:0] DATA_G0,
  input  logic [PIX_W-1:0] DATA_B0,
  input  logic [PIX_W-1:0] DATA_R1,
  input  logic [PIX_W-1:0] DATA_G1,
  input  logic [PIX_W-1:0] DATA_B1,
  output logic             HSYNC_O,
  output logic [PIX_W-1:0] DATA_R0_O,
  output logic [PIX_W-1:0] DATA_G0_O,
  output logic [PIX_W-1:0] DATA_B0_O,
  output logic [PIX_W-1:0] DATA_R1_O,
  output logic [PIX_W-1:0] DATA_G1_O,
  output logic [PIX_W-1:0] DATA_B1_O,
  output logic             frame_done
);
  localparam int PAIRS = WIDTH / 2;
  localparam int KW = $clog2(PAIRS);
  localparam int LW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);
  localparam logic [LW-1:0] L_LAST = LW'(HEIGHT - 1);
  logic [KW-1:0] k;
  logic [LW-1:0] line;
  logic flush, p_en, s_en, en, emit;
  pair_t d, p, s, q, src, y;
  rgb_t l, sl, left, right;
  assign d = {{DATA_R1, DATA_G1, DATA_B1}, {DATA_R0, DATA_G0, DATA_B0}};
  assign {DATA_R0_O, DATA_G0_O, DATA_B0_O} = q[0];
  assign {DATA_R1_O, DATA_G1_O, DATA_B1_O} = q[1];
  always_comb begin
    src = flush ? s : p;
    en = flush ? s_en : p_en;
    left = flush ? sl : (k == KW'(1) ? p[0] : l);
    right = flush ? s[1] : d[0];
    emit = flush | (HSYNC & (k != '0));
  end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    hsmooth_tap3 u_even (.a(left[i]),   .b(src[0][i]), .c(src[1][i]), .y(y[0][i]));
    hsmooth_tap3 u_odd  (.a(src[0][i]), .b(src[1][i]), .c(right[i]),  .y(y[1][i]));
  end
  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      k <= '0;
      line <= '0;
      flush <= 1'b0;
      p <= '0;
      l <= '0;
      p_en <= 1'b0;
      s <= '0;
      sl <= '0;
      s_en <= 1'b0;
      q <= '0;
      HSYNC_O <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      HSYNC_O <= emit;
      frame_done <= flush && line == L_LAST;
      if (emit) q <= en ? y : src;
      if (flush) begin
        flush <= 1'b0;
        line <= line == L_LAST ? '0 : line + 1'b1;
      end
      if (HSYNC) begin
        p <= d;
        l <= p[1];
        p_en <= ENABLE;
        k <= k == K_LAST ? '0 : k + 1'b1;
        if (k == K_LAST) begin
          flush <= 1'b1;
          s <= d;
          sl <= p[1];
          s_en <= ENABLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_hsmooth_filter.sv
// tb_hsmooth_filter: randomized and directed checks of hsmooth_filter against a line-buffer reference model
module tb_hsmooth_filter;
  localparam int W = 8;
  localparam int H = 2;
  localparam int NP = W / 2;
  logic HCLK = 0, HRESET = 0, ENABLE = 0, HSYNC = 0;
  logic [7:0] DATA_R0 = 0, DATA_G0 = 0, DATA_B0 = 0, DATA_R1 = 0, DATA_G1 = 0, DATA_B1 = 0;
  logic HSYNC_O, frame_done;
  logic [7:0] DATA_R0_O, DATA_G0_O, DATA_B0_O, DATA_R1_O, DATA_G1_O, DATA_B1_O;
  int errors = 0, checks = 0;
  int k = 0, ln = 0, cnt_hs = 0, cnt_fd = 0;
  bit pend = 0, exp_hs = 0, exp_fd = 0;
  bit [23:0] pix[W];
  bit pen[NP];
  bit [23:0] lb[W];
  bit [47:0] exp_d = 0;
  int robs[$];
  int gpat[NP] = '{0, 2, 0, 1};
  int ramp_exp[W] = '{3, 10, 20, 30, 40, 50, 60, 68};
  int imp_exp[W] = '{0, 0, 64, 128, 64, 0, 0, 0};
  always #5 HCLK = ~HCLK;
  hsmooth_filter #(.WIDTH(W), .HEIGHT(H)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .ENABLE(ENABLE), .HSYNC(HSYNC),
    .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
    .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
    .HSYNC_O(HSYNC_O),
    .DATA_R0_O(DATA_R0_O), .DATA_G0_O(DATA_G0_O), .DATA_B0_O(DATA_B0_O),
    .DATA_R1_O(DATA_R1_O), .DATA_G1_O(DATA_G1_O), .DATA_B1_O(DATA_B1_O),
    .frame_done(frame_done)
  );
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask
  function automatic bit [23:0] filt(input int i, input bit e);
    bit [23:0] r;
    int a, b, c;
    if (!e) return pix[i];
    for (int ch = 0; ch < 3; ch++) begin
      a = pix[i > 0 ? i - 1 : 0][8*ch+:8];
      b = pix[i][8*ch+:8];
      c = pix[i < W - 1 ? i + 1 : W - 1][8*ch+:8];
      r[8*ch+:8] = 8'((a + 2 * b + c + 2) / 4);
    end
    return r;
  endfunction
  function automatic bit [47:0] fpair(input int j);
    return {filt(2 * j + 1, pen[j]), filt(2 * j, pen[j])};
  endfunction
  task automatic model(input bit hs, input bit [47:0] d, input bit en, input bit rn);
    exp_hs = 0;
    exp_fd = 0;
    if (!rn) begin
      k = 0;
      ln = 0;
      pend = 0;
      exp_d = 0;
    end else begin
      if (pend) begin
        exp_d = fpair(NP - 1);
        exp_hs = 1;
        exp_fd = (ln == H - 1);
        ln = (ln + 1) % H;
        pend = 0;
      end
      if (hs) begin
        pix[2*k] = d[23:0];
        pix[2*k+1] = d[47:24];
        pen[k] = en;
        if (k > 0) begin
          exp_d = fpair(k - 1);
          exp_hs = 1;
        end
        if (k == NP - 1) pend = 1;
        k = (k + 1) % NP;
      end
    end
  endtask
  task automatic step(input bit hs, input bit [47:0] d, input bit en, input bit rn);
    HSYNC = hs;
    ENABLE = en;
    HRESET = rn;
    {DATA_R0, DATA_G0, DATA_B0} = d[23:0];
    {DATA_R1, DATA_G1, DATA_B1} = d[47:24];
    @(posedge HCLK);
    model(hs, d, en, rn);
    #1;
    chk("hsync_o", 48'(HSYNC_O), 48'(exp_hs));
    chk("frame_done", 48'(frame_done), 48'(exp_fd));
    chk(exp_hs ? "data" : "hold",
        {DATA_R1_O, DATA_G1_O, DATA_B1_O, DATA_R0_O, DATA_G0_O, DATA_B0_O}, exp_d);
    if (HSYNC_O) begin
      cnt_hs++;
      robs.push_back(int'(DATA_R0_O));
      robs.push_back(int'(DATA_R1_O));
    end
    if (frame_done) cnt_fd++;
  endtask
  task automatic idle();
    step(0, 48'({$urandom, $urandom}), 1'($urandom), 1);
  endtask
  task automatic send_line(input int en_mode, input int gap_mode);
    int g;
    for (int j = 0; j < NP; j++) begin
      g = gap_mode == 1 ? gpat[j] : gap_mode == 2 ? int'($urandom_range(0, 2)) : 0;
      repeat (g) idle();
      step(1, {lb[2*j+1], lb[2*j]}, en_mode == 2 ? 1'($urandom) : 1'(en_mode), 1);
    end
  endtask
  task automatic ramp();
    for (int i = 0; i < W; i++) lb[i] = {8'(10 * i), 16'd0};
  endtask
  task automatic chk_r(input string tag, input int want[W]);
    chk({tag, "_count"}, 48'(robs.size()), 48'(W));
    for (int i = 0; i < W && i < robs.size(); i++) chk(tag, 48'(robs[i]), 48'(want[i]));
  endtask
  initial begin
    repeat (2) step(0, 48'd0, 1, 0);
    for (int i = 0; i < W; i++) lb[i] = {3{8'd100}};
    cnt_hs = 0;
    cnt_fd = 0;
    send_line(1, 0);
    send_line(1, 0);
    idle();
    chk("pulses", 48'(cnt_hs), 48'(2 * NP));
    chk("frame_done_count", 48'(cnt_fd), 48'(1));
    ramp();
    robs.delete();
    send_line(1, 0);
    idle();
    chk_r("ramp", ramp_exp);
    for (int i = 0; i < W; i++) lb[i] = i == 3 ? 24'hffffff : 24'd0;
    robs.delete();
    send_line(1, 0);
    idle();
    chk_r("impulse", imp_exp);
    ramp();
    robs.delete();
    send_line(1, 1);
    idle();
    chk_r("ramp_gaps", ramp_exp);
    for (int i = 0; i < W; i++) lb[i] = {3{8'd200}};
    robs.delete();
    send_line(1, 0);
    for (int i = 0; i < W; i++) lb[i] = 24'd0;
    send_line(1, 0);
    idle();
    chk("b2b_a_last0", 48'(robs[6]), 48'(200));
    chk("b2b_a_last1", 48'(robs[7]), 48'(200));
    chk("b2b_b_first0", 48'(robs[8]), 48'(0));
    chk("b2b_b_first1", 48'(robs[9]), 48'(0));
    ramp();
    for (int j = 0; j < 3; j++) step(1, {lb[2*j+1], lb[2*j]}, 1, 1);
    step(0, 48'd0, 1, 0);
    robs.delete();
    send_line(0, 0);
    idle();
    for (int i = 0; i < W; i++) ramp_exp[i] = 10 * i;
    chk_r("bypass", ramp_exp);
    repeat (40) begin
      for (int i = 0; i < W; i++) lb[i] = 24'($urandom);
      send_line(2, 2);
      repeat ($urandom_range(0, 2)) idle();
    end
    repeat (3) idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
